fact_mmio: RTL and testbench

//  Memory-mapped factorial accelerator for the MIPS32 data bus. It integrates a
//  2-bit register decoder with the input, go, status and result registers and an

---
 rtl/fact_mmio.sv | 134 +++++++++++++
 tb/tb_fact_mmio.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fact_mmio.sv
// fact_mmio
//   Memory-mapped factorial accelerator for the MIPS32 data bus. Software
//   writes an operand n into the N register and then writes 1 to GO. An
//   iterative engine then multiplies down from n to 2, one step per clock.
//   Completion and overflow are reported in STATUS, and n! is read from RESULT.
//
// Parameters
//   DATA_W  bus and result width in bits
//   N_W     operand width; n ranges over 0..2^N_W-1 (N_W must be < DATA_W)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active low
//   a      register select: 00 N, 01 GO, 10 STATUS, 11 RESULT
//   we     write enable (already qualified by the system address decoder)
//   wd     write data
//   rd     read data, combinational from a and the registers
module fact_mmio #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        a,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [N_W-1:0]      n_reg;
  logic [N_W-1:0]      cnt;
  logic [DATA_W-1:0]   prod;
  logic [DATA_W-1:0]   result;
  logic                go, done, err, busy;

  logic                n_wr;
  logic                go_acc;
  logic                cnt_le1;
  logic [2*DATA_W-1:0] p;
  logic                p_ovf;

  // Only the low N_W bits of wd reach n_reg and only bit 0 matters for GO;
  // the remaining write-data bits are intentionally ignored.
  logic unused_wd;
  assign unused_wd = ^wd[DATA_W-1:N_W];

  assign n_wr    = we && (a == 2'b00);
  assign go_acc  = we && (a == 2'b01) && wd[0] && (state == IDLE);

  // cnt of 0 or 1 both mean "nothing left to multiply", so 0! and 1! finish
  // on the first busy cycle with prod still at 1.
  assign cnt_le1 = (cnt[N_W-1:1] == '0);

  // Full double-width product so any carry into the upper half is visible
  // as an overflow rather than silently truncated.
  assign p     = {{DATA_W{1'b0}}, prod} * {{(2*DATA_W-N_W){1'b0}}, cnt};
  assign p_ovf = (p[2*DATA_W-1:DATA_W] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_acc) state_nxt = BUSY;
      BUSY:    if (cnt_le1 || p_ovf) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register file and multiply engine. An N write is honoured in any state
  // but only feeds cnt when the next GO is accepted, so a running job never
  // sees it. done/err stay set until the next accepted GO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg  <= '0;
      cnt    <= '0;
      prod   <= '0;
      result <= '0;
      go     <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (n_wr) n_reg <= wd[N_W-1:0];
      case (state)
        IDLE: begin
          if (go_acc) begin
            cnt  <= n_reg;
            prod <= {{(DATA_W-1){1'b0}}, 1'b1};
            go   <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
            err  <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_le1) begin
            result <= prod;
            done   <= 1'b1;
            go     <= 1'b0;
            busy   <= 1'b0;
          end else if (p_ovf) begin
            result <= '0;
            err    <= 1'b1;
            done   <= 1'b1;
            go     <= 1'b0;
            busy   <= 1'b0;
          end else begin
            prod <= p[DATA_W-1:0];
            cnt  <= cnt - {{(N_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (a)
      2'b00:   rd = {{(DATA_W-N_W){1'b0}}, n_reg};
      2'b01:   rd = {{(DATA_W-1){1'b0}}, go};
      2'b10:   rd = {{(DATA_W-3){1'b0}}, busy, err, done};
      2'b11:   rd = result;
      default: rd = 'x;
    endcase
  end

endmodule

// File: tb/tb_fact_mmio.sv
// tb_fact_mmio
//   Self-checking bench for fact_mmio. Expected results, overflow flags and
//   completion latencies come from a plain-arithmetic factorial model.
module tb_fact_mmio;

  localparam int DATA_W = 32;
  localparam int N_W    = 4;

  logic              clk;
  logic              rst_n;
  logic [1:0]        a;
  logic              we;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;

  int checks = 0;
  int errors = 0;

  fact_mmio #(.DATA_W(DATA_W), .N_W(N_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .we    (we),
    .wd    (wd),
    .rd    (rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: n! by repeated multiplication from n down to 2, one step per
  // cycle, plus one cycle to publish. If a step exceeds DATA_W bits the job
  // ends on that step with err set and result 0.
  function automatic void model(input int n, output logic [DATA_W-1:0] res,
                                output logic ovf, output int lat);
    longint unsigned f;
    f   = 1;
    ovf = 1'b0;
    lat = 0;
    res = '0;
    for (int m = n; m >= 2; m--) begin
      lat++;
      f = f * longint'(m);
      if (f > 64'hFFFF_FFFF) begin
        ovf = 1'b1;
        return;
      end
    end
    lat++;
    res = f[DATA_W-1:0];
  endfunction

  task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    a  = addr;
    we = 1'b1;
    wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [DATA_W-1:0] data);
    a = addr;
    #1;
    data = rd;
  endtask

  // Write N (with random junk above the operand bits) and an accepted GO.
  task automatic apply_stimulus(input int n);
    logic [DATA_W-1:0] v;
    write_reg(2'b00, ($urandom() & 32'hFFFF_FFF0) | DATA_W'(n));
    read_reg(2'b00, v);
    check_output($sformatf("n_readback n=%0d", n), v, DATA_W'(n));
    write_reg(2'b01, $urandom() | 32'h1);
    read_reg(2'b10, v);
    check_output($sformatf("status_busy n=%0d", n), v, 32'h4);
    read_reg(2'b01, v);
    check_output($sformatf("go_set n=%0d", n), v, 32'h1);
  endtask

  // Step from edge e0+already+1 to completion, checking STATUS every cycle,
  // then RESULT and GO.
  task automatic wait_done(input int n, input int already);
    logic [DATA_W-1:0] exp_res, v;
    logic              exp_err;
    int                lat;
    model(n, exp_res, exp_err, lat);
    for (int c = already + 1; c <= lat; c++) begin
      @(negedge clk);
      read_reg(2'b10, v);
      check_output($sformatf("status n=%0d cyc=%0d", n, c), v,
                   (c < lat) ? 32'h4 : {29'b0, 1'b0, exp_err, 1'b1});
    end
    read_reg(2'b11, v);
    check_output($sformatf("result n=%0d", n), v, exp_res);
    read_reg(2'b01, v);
    check_output($sformatf("go_clear n=%0d", n), v, 32'h0);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    a     = 2'b00;
    we    = 1'b0;
    wd    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset: every register reads zero, during and after reset.
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check_output($sformatf("reset_rd a=%0d", i), v, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(2'b10, v);
    check_output("status_after_reset", v, 32'h0);

    // Basic 5! with fixed expectations alongside the model.
    apply_stimulus(5);
    wait_done(5, 0);
    read_reg(2'b11, v);
    check_output("result_5_const", v, 32'd120);

    // A read does not clear done; GO with bit0=0 and writes to STATUS/RESULT are ignored.
    write_reg(2'b01, 32'hFFFF_FFFE);
    write_reg(2'b10, 32'hFFFF_FFFF);
    write_reg(2'b11, 32'hDEAD_BEEF);
    read_reg(2'b10, v);
    check_output("status_sticky", v, 32'h1);
    read_reg(2'b01, v);
    check_output("go_ignored", v, 32'h0);
    read_reg(2'b11, v);
    check_output("result_ro", v, 32'd120);

    // Edges: 0!, 1!, 12!.
    apply_stimulus(0);
    wait_done(0, 0);
    apply_stimulus(1);
    wait_done(1, 0);
    apply_stimulus(12);
    wait_done(12, 0);
    read_reg(2'b11, v);
    check_output("result_12_const", v, 32'd479001600);

    // Overflow then recovery.
    apply_stimulus(13);
    wait_done(13, 0);
    read_reg(2'b10, v);
    check_output("status_ovf_const", v, 32'h3);
    apply_stimulus(3);
    wait_done(3, 0);
    read_reg(2'b11, v);
    check_output("result_3_const", v, 32'd6);

    // Interference: N and GO writes mid-run. GO is accepted at e0; the N write
    // lands on e2 and the dropped GO on e4, so four edges have passed.
    apply_stimulus(6);
    write_reg(2'b00, 32'd2);
    write_reg(2'b01, 32'd1);
    wait_done(6, 4);
    read_reg(2'b11, v);
    check_output("result_6_const", v, 32'd720);
    read_reg(2'b00, v);
    check_output("n_updated", v, 32'd2);
    write_reg(2'b01, 32'd1);
    wait_done(2, 0);

    // Abort: reset asserted after three busy edges of a 10! run.
    apply_stimulus(10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check_output($sformatf("abort_rd a=%0d", i), v, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4);
    wait_done(4, 0);

    // Randomized operands against the model.
    for (int k = 0; k < 12; k++) begin
      int n;
      n = int'($urandom_range(0, 15));
      apply_stimulus(n);
      wait_done(n, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
